// File: rtl/video_timing_gen_if.sv
// Pixel stream into the timing generator and the video bus it drives.
// The master side is the timing generator; the slave side is the source/sink around it.
interface video_timing_gen_if;
    localparam int unsigned DW = 32;

    logic [DW-1:0] pix;
    logic          pix_valid;
    logic          pix_ready;
    logic          hsync;
    logic          vsync;
    logic          blank;
    logic          border;
    logic [DW-1:0] data;
    logic          sof;

    modport master (
        input  pix, pix_valid,
        output pix_ready, hsync, vsync, blank, border, data, sof
    );

    modport slave (
        output pix, pix_valid,
        input  pix_ready, hsync, vsync, blank, border, data, sof
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters, sync/blank/border decode,
// window pixel pull from upstream with sticky underrun detection.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE  = 800,
    parameter int unsigned H_FP      = 40,
    parameter int unsigned H_SYNC    = 128,
    parameter int unsigned H_BP      = 88,
    parameter int unsigned V_ACTIVE  = 600,
    parameter int unsigned V_FP      = 1,
    parameter int unsigned V_SYNC    = 4,
    parameter int unsigned V_BP      = 23,
    parameter int unsigned H_BORDER  = 0,
    parameter int unsigned V_BORDER  = 0,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] border_color,
    input  logic        underrun_clr,
    output logic        underrun,
    output logic [11:0] hctr,
    output logic [11:0] vctr,
    video_timing_gen_if.master vbus
);

    localparam int unsigned CW      = 12;
    localparam int unsigned XW      = CW + 1;
    localparam int unsigned DW      = 32;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned WH_END  = H_ACTIVE - H_BORDER;
    localparam int unsigned WV_END  = V_ACTIVE - V_BORDER;

    if (H_TOTAL > 4096 || V_TOTAL > 4096 ||
        2 * H_BORDER >= H_ACTIVE || 2 * V_BORDER >= V_ACTIVE) begin : g_bad_params
        $error("video_timing_gen: illegal timing parameters");
    end

    logic [CW-1:0] h_q, v_q, h_nxt, v_nxt;
    logic [CW-1:0] hctr_q, vctr_q;
    logic [XW-1:0] h_x, v_x;
    logic          h_last_c, v_last_c, origin_c;
    logic          active_c, win_c, bord_c, hs_c, vs_c;
    logic          sof_pend_q, sof_pend_d;
    logic          hsync_q, vsync_q, blank_q, border_q, sof_q, underrun_q;
    logic          hsync_d, vsync_d, blank_d, border_d, sof_d, underrun_d;
    logic [DW-1:0] data_q, data_d;

    // Region decode, widened by one bit so boundaries at 4096 compare correctly.
    assign h_x      = {1'b0, h_q};
    assign v_x      = {1'b0, v_q};
    assign h_last_c = (h_q == CW'(H_TOTAL - 1));
    assign v_last_c = (v_q == CW'(V_TOTAL - 1));
    assign origin_c = (h_q == '0) && (v_q == '0);
    assign active_c = (h_x < XW'(H_ACTIVE)) && (v_x < XW'(V_ACTIVE));
    assign win_c    = active_c
                    && (h_x >= XW'(H_BORDER)) && (h_x < XW'(WH_END))
                    && (v_x >= XW'(V_BORDER)) && (v_x < XW'(WV_END));
    assign bord_c   = active_c && !win_c;
    assign hs_c     = (h_x >= XW'(HS_BEG)) && (h_x < XW'(HS_END));
    assign vs_c     = (v_x >= XW'(VS_BEG)) && (v_x < XW'(VS_END));

    assign vbus.pix_ready = rst_n & en & win_c;

    // Next counter state and next registered outputs; en=0 freezes and blanks.
    always_comb begin
        h_nxt      = h_q;
        v_nxt      = v_q;
        hsync_d    = !HSYNC_POL;
        vsync_d    = !VSYNC_POL;
        blank_d    = 1'b1;
        border_d   = 1'b0;
        data_d     = '0;
        sof_d      = 1'b0;
        sof_pend_d = sof_pend_q;
        underrun_d = underrun_q & !underrun_clr;
        if (en) begin
            if (h_last_c) begin
                h_nxt = '0;
                v_nxt = v_last_c ? '0 : v_q + CW'(1);
            end else begin
                h_nxt = h_q + CW'(1);
            end
            if (hs_c) hsync_d = HSYNC_POL;
            if (vs_c) vsync_d = VSYNC_POL;
            blank_d  = !active_c;
            border_d = bord_c;
            if (win_c) data_d = vbus.pix_valid ? vbus.pix : '0;
            else if (bord_c) data_d = border_color;
            // sof is owed once per arrival at the origin, not per enabled cycle spent there.
            sof_d      = sof_pend_q & origin_c;
            sof_pend_d = h_last_c & v_last_c;
            if (win_c && !vbus.pix_valid) underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q        <= '0;
            v_q        <= '0;
            hctr_q     <= '0;
            vctr_q     <= '0;
            hsync_q    <= !HSYNC_POL;
            vsync_q    <= !VSYNC_POL;
            blank_q    <= 1'b1;
            border_q   <= 1'b0;
            data_q     <= '0;
            sof_q      <= 1'b0;
            sof_pend_q <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            h_q        <= h_nxt;
            v_q        <= v_nxt;
            hctr_q     <= h_q;
            vctr_q     <= v_q;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            blank_q    <= blank_d;
            border_q   <= border_d;
            data_q     <= data_d;
            sof_q      <= sof_d;
            sof_pend_q <= sof_pend_d;
            underrun_q <= underrun_d;
        end
    end

    assign vbus.hsync  = hsync_q;
    assign vbus.vsync  = vsync_q;
    assign vbus.blank  = blank_q;
    assign vbus.border = border_q;
    assign vbus.data   = data_q;
    assign vbus.sof    = sof_q;
    assign underrun    = underrun_q;
    assign hctr        = hctr_q;
    assign vctr        = vctr_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a raster-position reference model queues expected
// outputs per cycle; a negedge monitor pops and compares, and also tallies per-frame statistics.
module tb_video_timing_gen;

    localparam int unsigned HT = 16;
    localparam int unsigned VT = 8;
    localparam int unsigned FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        underrun_clr;
    logic [31:0] border_color;
    logic        underrun;
    logic [11:0] hctr;
    logic [11:0] vctr;

    video_timing_gen_if bus ();

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_BORDER(1), .V_BORDER(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .border_color (border_color),
        .underrun_clr (underrun_clr),
        .underrun     (underrun),
        .hctr         (hctr),
        .vctr         (vctr),
        .vbus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank;
        logic        border;
        logic [31:0] data;
        logic        sof;
        logic        und;
        logic [11:0] hc;
        logic [11:0] vc;
        logic        ready;
        logic        en_used;
        logic        rst_used;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;

    // Reference model state: linear raster position within the frame.
    int          p          = 0;
    logic [31:0] pix_cnt    = 32'd0;
    bit          m_und      = 1'b0;
    bit          m_sof_pend = 1'b1;
    exp_t        prev;
    bit          have_prev  = 1'b0;

    function automatic bit in_act(int pos);
        return (pos % HT) < 8 && (pos / HT) < 4;
    endfunction

    function automatic bit in_win(int pos);
        int h = pos % HT;
        int v = pos / HT;
        return h >= 1 && h < 7 && v >= 1 && v < 3;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock of stimulus: drive inputs, queue expectations, advance the model.
    task automatic step(input bit r, input bit e, input bit pv, input bit c);
        exp_t nx;
        int   h;
        int   v;
        bit   act;
        bit   w;
        rst_n         = r;
        en            = e;
        bus.pix_valid = pv;
        underrun_clr  = c;
        bus.pix       = pix_cnt;
        h   = p % HT;
        v   = p / HT;
        act = in_act(p);
        w   = in_win(p);
        if (have_prev) begin
            prev.ready = r & e & w;
            q.push_back(prev);
        end
        nx          = '0;
        nx.en_used  = e;
        nx.rst_used = r;
        if (!r) begin
            nx.blank   = 1'b1;
            p          = 0;
            m_und      = 1'b0;
            m_sof_pend = 1'b1;
        end else begin
            nx.hc = 12'(h);
            nx.vc = 12'(v);
            if (!e) begin
                nx.blank = 1'b1;
                if (c) m_und = 1'b0;
            end else begin
                nx.hs     = (h >= 10 && h < 13);
                nx.vs     = (v >= 5 && v < 7);
                nx.blank  = !act;
                nx.border = act && !w;
                nx.data   = w ? (pv ? pix_cnt : 32'd0) : (act ? border_color : 32'd0);
                nx.sof    = m_sof_pend && p == 0;
                m_sof_pend = (p == FT - 1);
                if (w && !pv) m_und = 1'b1;
                else if (c) m_und = 1'b0;
                if (w && pv) pix_cnt++;
                p = (p + 1) % FT;
            end
        end
        nx.und    = m_und;
        prev      = nx;
        have_prev = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int t);
        for (int i = 0; i < FT && p != t; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    // Monitor: per-cycle compare plus frame statistics over uninterrupted frames.
    int frm_period  = 0;
    int frm_active  = 0;
    int frm_vs      = 0;
    int frm_win     = 0;
    bit frm_clean   = 1'b0;
    bit frm_started = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("hsync",     32'(bus.hsync),     32'(e.hs));
            chk("vsync",     32'(bus.vsync),     32'(e.vs));
            chk("blank",     32'(bus.blank),     32'(e.blank));
            chk("border",    32'(bus.border),    32'(e.border));
            chk("data",      bus.data,           e.data);
            chk("sof",       32'(bus.sof),       32'(e.sof));
            chk("underrun",  32'(underrun),      32'(e.und));
            chk("hctr",      32'(hctr),          32'(e.hc));
            chk("vctr",      32'(vctr),          32'(e.vc));
            chk("pix_ready", 32'(bus.pix_ready), 32'(e.ready));
            if (bus.sof === 1'b1) begin
                if (frm_started && frm_clean) begin
                    chk("sof_period",   32'(frm_period), 32'(FT));
                    chk("active_beats", 32'(frm_active), 32'd32);
                    chk("vsync_beats",  32'(frm_vs),     32'd32);
                    chk("window_beats", 32'(frm_win),    32'd12);
                end
                frm_period  = 0;
                frm_active  = 0;
                frm_vs      = 0;
                frm_win     = 0;
                frm_clean   = 1'b1;
                frm_started = 1'b1;
            end
            if (!e.en_used || !e.rst_used) frm_clean = 1'b0;
            frm_period++;
            if (bus.blank === 1'b0) frm_active++;
            if (bus.vsync === 1'b1) frm_vs++;
            if (bus.blank === 1'b0 && bus.border === 1'b0) frm_win++;
        end
    end

    initial begin
        rst_n         = 1'b0;
        en            = 1'b0;
        underrun_clr  = 1'b0;
        border_color  = 32'hDEADBEEF;
        bus.pix       = 32'd0;
        bus.pix_valid = 1'b0;
        #1;
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);

        // Three clean frames with incrementing pixels and a fixed border colour.
        repeat (3 * FT) step(1'b1, 1'b1, 1'b1, 1'b0);

        // Starve at line 2 column 3, hold, then clear coinciding with a fresh starvation.
        run_to(2 * HT + 3);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (20) step(1'b1, 1'b1, 1'b1, 1'b0);
        run_to(HT + 2);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (10) step(1'b1, 1'b1, 1'b1, 1'b0);

        // Mid-frame reset at column 5 line 2.
        run_to(2 * HT + 5);
        repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (FT + 10) step(1'b1, 1'b1, 1'b1, 1'b0);

        // Enable drop mid-window.
        run_to(HT + 3);
        repeat (5) step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (FT + 20) step(1'b1, 1'b1, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 63) == 0) border_color = $urandom;
            step($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
- REQ-001: The block SHALL be clocked on the rising edge of `clk` only, with synchronous, active-low reset `rst_n`.
- REQ-002: Parameters (name, default, meaning) SHALL be:
  - H_ACTIVE, 800, visible pixels per line.
  - H_FP, 40, horizontal front porch.
  - H_SYNC, 128, hsync width.
  - H_BP, 88, horizontal back porch.
  - V_ACTIVE, 600, visible lines.
  - V_FP, 1, vertical front porch.
  - V_SYNC, 4, vsync width.
  - V_BP, 23, vertical back porch.
  - H_BORDER, 0, border pixels at each side.
  - V_BORDER, 0, border lines at top and bottom.
  - HSYNC_POL, 1, 1 = hsync active high.
  - VSYNC_POL, 1, 1 = vsync active high.
- REQ-003: Ports (name, direction, width, meaning) SHALL be:
  - clk, in, 1, pixel clock.
  - rst_n, in, 1, synchronous active-low reset.
  - en, in, 1, timing enable.
  - border_color, in, 32, border pixel value.
  - pix, in, 32, upstream pixel.
  - pix_valid, in, 1, pixel available.
  - pix_ready, out, 1, pixel consumed this cycle when pix_valid is also high.
  - underrun_clr, in, 1, clears underrun.
  - hsync, vsync, blank, border, out, 1 each, video bus controls.
  - data, out, 32, video bus pixel.
  - sof, out, 1, start-of-frame pulse.
  - underrun, out, 1, sticky starvation flag.
  - hctr, out, 12, current column.
  - vctr, out, 12, current line.

Function
- REQ-004: H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP.
- REQ-005: hctr SHALL increment each cycle while en=1 and wrap H_TOTAL-1 -> 0; vctr SHALL increment on that wrap and wrap V_TOTAL-1 -> 0 when both counters are at their maximum.
- REQ-006: While en=0, both counters SHALL hold their current value.
- REQ-007: Timing regions SHALL be defined on the counter values:
  - active = (hctr<H_ACTIVE) & (vctr<V_ACTIVE).
  - win = active & hctr>=H_BORDER & hctr<H_ACTIVE-H_BORDER & vctr>=V_BORDER & vctr<V_ACTIVE-V_BORDER.
  - bord = active & !win.
- REQ-008: pix_ready SHALL be combinational and equal rst_n & en & win.
- REQ-009: A pixel SHALL be consumed only when pix_ready & pix_valid; upstream SHALL NOT see pix_ready in any non-window cycle.
- REQ-010: All video outputs SHALL be registered, with exactly one cycle of latency from the counter state that produced them.
- REQ-011: hsync SHALL be asserted (at level HSYNC_POL) when H_ACTIVE+H_FP <= hctr < H_ACTIVE+H_FP+H_SYNC, and SHALL be inactive otherwise.
- REQ-012: vsync SHALL be asserted (at level VSYNC_POL) when V_ACTIVE+V_FP <= vctr < V_ACTIVE+V_FP+V_SYNC, on all columns of those lines.
- REQ-013: blank SHALL equal !active; border SHALL equal bord.
- REQ-014: data SHALL be selected as follows:
  - pix, when win & pix_valid.
  - 0, when win & !pix_valid.
  - border_color, when bord.
  - 0, when blanked.
- REQ-015: underrun SHALL set in the same registered cycle as a win & !pix_valid data beat.
- REQ-016: underrun SHALL clear on underrun_clr=1; if set and clear coincide, set SHALL win.
- REQ-017: sof SHALL pulse for one cycle, with registered timing, for each counter state hctr=0, vctr=0 reached while en=1.
- REQ-018: hctr and vctr outputs SHALL be registered copies aligned with the video outputs.
- REQ-019: When en=0, outputs SHALL present blank=1, border=0, data=0, sof=0, and inactive syncs.
- REQ-020: Counter arithmetic SHALL be unsigned 12-bit; parameters SHALL satisfy H_TOTAL, V_TOTAL <= 4096 and 2*H_BORDER < H_ACTIVE, 2*V_BORDER < V_ACTIVE (an elaboration-time assertion is required).

Reset
- REQ-021: rst_n=0 at a rising edge SHALL force, on the next cycle:
  - counters = 0.
  - hsync = !HSYNC_POL, vsync = !VSYNC_POL.
  - blank = 1, border = 0, data = 0, sof = 0, underrun = 0.
  - hctr/vctr outputs = 0.
  - pix_ready = 0.
- REQ-022: Reset asserted mid-line or mid-frame SHALL abandon the frame; after release, timing SHALL restart at hctr=0, vctr=0 and sof SHALL pulse one cycle later.

Verification
Bench parameters: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=16); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); H_BORDER=1, V_BORDER=1; polarity 1.
- REQ-023: Release reset, en=1, pix_valid=1 -> sof high in the 1st output cycle; hsync high for 3 cycles starting at output column 10, repeating every 16 cycles; sof period 128 cycles.
- REQ-024: Run a full frame -> vsync high for 32 consecutive cycles during lines 5-6; blank=0 for exactly 32 cycles per frame.
- REQ-025: Set border_color=0xDEADBEEF and drive an incrementing pix -> line 0 gives 8 beats of 0xDEADBEEF; line 1 gives border at columns 0 and 7, with pixels 0..5 at columns 1-6; 12 pixels consumed per frame.
- REQ-026: Drop pix_valid at line 2 column 3 -> data=0 for that beat; underrun=1 from that output cycle; it stays set until underrun_clr; clr and a new underrun in the same cycle leave underrun=1.
- REQ-027: Assert rst_n=0 at hctr=5, vctr=2 for 2 cycles -> reset values appear the next cycle; after release, counters restart at 0,0 and sof pulses once.
- REQ-028: Drop en=0 for 5 cycles mid-window -> pix_ready=0, blank=1, counters frozen; resume continues from the held hctr/vctr with no sof.
